// File: rtl/kamus_mc_cu.sv
// Multi-cycle control unit: sequences fetch, decode, execute, memory and
// writeback, with a bounded wait on each memory handshake.
module kamus_mc_cu #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] op_class_i,
  input  logic       branch_taken_i,
  input  logic       stall_i,
  output logic       imem_req_o,
  input  logic       imem_ack_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_ack_i,
  output logic       ir_we_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [2:0] C_ALU   = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_STORE = 3'd2;
  localparam logic [2:0] C_BR    = 3'd3;
  localparam logic [2:0] C_JMP   = 3'd4;

  localparam logic [TO_W-1:0] W_LIM = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic [2:0]      r_cls;
  logic            r_taken;

  logic w_mem_op;
  logic w_wr;
  logic w_go;

  assign w_mem_op = (r_cls == C_LOAD) || (r_cls == C_STORE);
  assign w_wr     = (r_cls == C_ALU) || (r_cls == C_LOAD)
                 || (r_cls == C_JMP);

  // The limit is checked against the pre-increment count so that an ack
  // on the final allowed cycle still completes the access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_cls   <= C_ALU;
      r_taken <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_ack_i)          r_state <= S_DECODE;
          else if (r_cnt == W_LIM) r_state <= S_ERROR;
          else                     r_cnt   <= r_cnt + 1'b1;
        end
        S_DECODE: begin
          if (!stall_i) begin
            r_cls   <= op_class_i;
            r_state <= (op_class_i > C_JMP) ? S_ERROR : S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall_i) begin
            r_taken <= branch_taken_i;
            if (w_mem_op) begin
              r_state <= S_MEM;
              r_cnt   <= '0;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_MEM: begin
          if (dmem_ack_i)          r_state <= S_WB;
          else if (r_cnt == W_LIM) r_state <= S_ERROR;
          else                     r_cnt   <= r_cnt + 1'b1;
        end
        S_WB: begin
          if (!stall_i) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  // Outputs are gated by reset so an in-flight access drops immediately.
  assign w_go = rst_ni && (r_state == S_WB) && !stall_i;

  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    wb_sel_o   = 2'd0;
    pc_sel_o   = 2'd0;
    if (rst_ni) begin
      unique case (r_state)
        S_FETCH: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ack_i;
        end
        S_MEM: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = (r_cls == C_STORE);
        end
        default: ;
      endcase
    end
    if (w_go) begin
      pc_we_o = 1'b1;
      rf_we_o = w_wr;
    end
    if (rst_ni && r_state == S_WB) begin
      unique case (1'b1)
        (r_cls == C_JMP):         pc_sel_o = 2'd2;
        (r_cls == C_BR) && r_taken: pc_sel_o = 2'd1;
        default:                  pc_sel_o = 2'd0;
      endcase
    end
    if (rf_we_o) begin
      unique case (1'b1)
        (r_cls == C_LOAD): wb_sel_o = 2'd1;
        (r_cls == C_JMP):  wb_sel_o = 2'd2;
        default:           wb_sel_o = 2'd0;
      endcase
    end
  end

  assign err_o   = (r_state == S_ERROR);
  assign state_o = r_state;

endmodule

// File: doc/kamus_mc_cu.md
KAMUS_MC_CU -- requirements
Module: kamus_mc_cu

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory ack before a bus error; legal range 1..255.
REQ-002 SHALL have parameter TO_W, default $clog2(MEM_TIMEOUT+1): timeout counter width.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk_i  in  1  clock; all state changes on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 op_class_i  in  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP (JAL/JALR), 5-7 ILLEGAL.
REQ-007 branch_taken_i  in  1  branch comparator result, valid in EXEC.
REQ-008 stall_i  in  1  external hold request.
REQ-009 imem_req_o  out  1  instruction fetch request; imem_ack_i  in  1  fetch data valid.
REQ-010 dmem_req_o  out  1  data access request; dmem_we_o  out  1  store when 1; dmem_ack_i  in  1  access done.
REQ-011 ir_we_o  out  1  instruction register load strobe.
REQ-012 rf_we_o  out  1  register file write strobe.
REQ-013 wb_sel_o  out  2  writeback source: 0 ALU result, 1 memory result, 2 PC+4.
REQ-014 pc_we_o  out  1  PC update strobe; pc_sel_o  out  2  0 PC+4, 1 branch target, 2 jump target.
REQ-015 err_o  out  1  sticky fault flag; state_o  out  3  current state encoding.

Function
REQ-016 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7; state_o SHALL equal the current encoding.
REQ-017 FETCH: imem_req_o=1; on imem_ack_i=1, ir_we_o=1 in that cycle (combinational) and next state DECODE.
REQ-018 DECODE: op_class_i SHALL be registered into an internal class register; ILLEGAL -> ERROR, else -> EXEC.
REQ-019 EXEC: ALU, BRANCH, JUMP -> WB; LOAD, STORE -> MEM; branch_taken_i SHALL be registered in EXEC for use in WB.
REQ-020 MEM: dmem_req_o=1, dmem_we_o=1 only for STORE; on dmem_ack_i=1 -> WB.
REQ-021 WB (one cycle unless stalled): pc_we_o=1, then -> FETCH; rf_we_o=1 for ALU, LOAD, JUMP, else 0.
REQ-022 WB decoding: ALU wb_sel_o=0; LOAD wb_sel_o=1; JUMP wb_sel_o=2, pc_sel_o=2; BRANCH pc_sel_o=1 if registered taken else 0; all others pc_sel_o=0; wb_sel_o=0 when rf_we_o=0.
REQ-023 Minimum latency with same-cycle ack: ALU/BRANCH/JUMP 4 cycles, LOAD/STORE 5 cycles, FETCH entry to next FETCH entry.
REQ-024 Timeout counter SHALL clear on entry to FETCH or MEM and increment each cycle the request is held without ack; reaching MEM_TIMEOUT without ack -> ERROR; ack in the same cycle as the limit wins.
REQ-025 stall_i=1 SHALL hold state in DECODE, EXEC and WB and force rf_we_o=0, pc_we_o=0; stall_i SHALL be ignored in FETCH, MEM and ERROR.
REQ-026 ERROR: all strobes and requests 0, err_o=1, state held until reset.
REQ-027 ir_we_o, rf_we_o, pc_we_o SHALL each be high at most one cycle per instruction.
REQ-028 Acks arriving outside FETCH/MEM SHALL be ignored.

Reset
REQ-029 rst_ni=0 SHALL immediately force state FETCH, counter 0, class register ALU, err_o=0, all strobes 0; imem_req_o SHALL be 1 in the first cycle after release.
REQ-030 Reset asserted mid-access SHALL abandon the access with no PC or register-file write.

Verification
REQ-031 ALU op with imem_ack_i tied 1 -> states 0,1,2,4,0; rf_we_o and pc_we_o high only in cycle 4; wb_sel_o=0.
REQ-032 LOAD with dmem_ack_i after 3 wait cycles -> dmem_req_o high 4 cycles, dmem_we_o=0, then WB with rf_we_o=1, wb_sel_o=1.
REQ-033 BRANCH with branch_taken_i=1 -> WB pc_sel_o=1, rf_we_o=0; with branch_taken_i=0 -> pc_sel_o=0.
REQ-034 MEM_TIMEOUT=4 with imem_ack_i held 0 -> ERROR after 4 request cycles, err_o=1, imem_req_o=0 until reset.
REQ-035 op_class_i=6 in DECODE -> ERROR, no strobes; stall_i=1 for 3 cycles in WB -> pc_we_o delayed 3 cycles and pulsed once.
REQ-036 rst_ni low during MEM with a STORE -> state 0, dmem_req_o=0 asynchronously, pc_we_o never asserted.
